// File: rtl/sdram32_ctrl.sv
// sdram32_ctrl: two-port round-robin controller sequencing ROW/COL/ACC strobes for a 32x8 RAS/CAS memory.
// Optional macro SDRAM32_CTRL_ROW_HIT_EN: skip the ROW cycle when the request hits the last opened row.
module sdram32_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0_valid,
  input  logic       req0_we,
  input  logic [4:0] req0_addr,
  input  logic [7:0] req0_wdata,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic       req1_we,
  input  logic [4:0] req1_addr,
  input  logic [7:0] req1_wdata,
  output logic       req1_ready,
  output logic       rsp_valid,
  output logic       rsp_id,
  output logic [7:0] rsp_rdata,
  output logic       busy,
  output logic       mem_en,
  output logic       mem_rw,
  output logic       mem_ras,
  output logic       mem_cas,
  output logic [4:0] mem_address,
  output logic [7:0] mem_datain,
  input  logic [7:0] mem_dataout
);
  typedef enum logic [2:0] {IDLE, ROW, COL, ACC, CAP} state_t;

  state_t     state, state_nxt;
  logic       prio;
  logic       lat_we;
  logic [4:0] lat_addr;
  logic [7:0] lat_wdata;
  logic       lat_id;
  logic       grant, hs, row_hit;
  logic       sel_we;
  logic [4:0] sel_addr;
  logic [7:0] sel_wdata;

  // Pointer only matters when both requesters are valid at once.
  always_comb begin
    grant     = (req0_valid && req1_valid) ? prio : req1_valid;
    sel_we    = grant ? req1_we    : req0_we;
    sel_addr  = grant ? req1_addr  : req0_addr;
    sel_wdata = grant ? req1_wdata : req0_wdata;
    hs        = !rst && (state == IDLE) && (req0_valid || req1_valid);
  end

  assign req0_ready = hs && !grant;
  assign req1_ready = hs && grant;
  assign busy       = (state != IDLE);

`ifdef SDRAM32_CTRL_ROW_HIT_EN
  logic [2:0] open_row;
  logic       open_valid;

  assign row_hit = open_valid && (open_row == sel_addr[4:2]);

  always_ff @(posedge clk) begin
    if (rst) begin
      open_row   <= 3'd0;
      open_valid <= 1'b0;
    end else if (state == ROW) begin
      open_row   <= lat_addr[4:2];
      open_valid <= 1'b1;
    end
  end
`else
  assign row_hit = 1'b0;
`endif

  // Strobes decode only from state and the latched request.
  always_comb begin
    state_nxt   = state;
    mem_ras     = 1'b1;
    mem_cas     = 1'b1;
    mem_en      = 1'b0;
    mem_rw      = 1'b0;
    mem_address = 5'd0;
    mem_datain  = 8'd0;
    case (state)
      IDLE: if (hs) state_nxt = row_hit ? COL : ROW;
      ROW: begin
        mem_ras     = 1'b0;
        mem_address = {lat_addr[4:2], 2'b00};
        state_nxt   = COL;
      end
      COL: begin
        mem_cas     = 1'b0;
        mem_address = {3'b000, lat_addr[1:0]};
        state_nxt   = ACC;
      end
      ACC: begin
        mem_en     = 1'b1;
        mem_rw     = lat_we;
        mem_datain = lat_wdata;
        state_nxt  = lat_we ? IDLE : CAP;
      end
      CAP:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      prio      <= 1'b0;
      lat_we    <= 1'b0;
      lat_addr  <= 5'd0;
      lat_wdata <= 8'd0;
      lat_id    <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_id    <= 1'b0;
      rsp_rdata <= 8'd0;
    end else begin
      state     <= state_nxt;
      rsp_valid <= (state == CAP);
      if (hs) begin
        lat_we    <= sel_we;
        lat_addr  <= sel_addr;
        lat_wdata <= sel_wdata;
        lat_id    <= grant;
        prio      <= ~grant;
      end
      if (state == CAP) begin
        rsp_rdata <= mem_dataout;
        rsp_id    <= lat_id;
      end
    end
  end
endmodule

// File: tb/tb_sdram32_ctrl.sv
// Directed bench for sdram32_ctrl with a behavioural RAS/CAS memory (registered read data).
module tb_sdram32_ctrl;
`ifdef SDRAM32_CTRL_ROW_HIT_EN
  localparam bit HIT = 1'b1;
`else
  localparam bit HIT = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req0_valid = 1'b0, req0_we = 1'b0;
  logic [4:0] req0_addr = 5'd0;
  logic [7:0] req0_wdata = 8'd0;
  logic       req0_ready;
  logic       req1_valid = 1'b0, req1_we = 1'b0;
  logic [4:0] req1_addr = 5'd0;
  logic [7:0] req1_wdata = 8'd0;
  logic       req1_ready;
  logic       rsp_valid, rsp_id, busy;
  logic [7:0] rsp_rdata;
  logic       mem_en, mem_rw, mem_ras, mem_cas;
  logic [4:0] mem_address;
  logic [7:0] mem_datain;
  logic [7:0] mem_dataout = 8'd0;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  sdram32_ctrl dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_we(req0_we), .req0_addr(req0_addr),
    .req0_wdata(req0_wdata), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_we(req1_we), .req1_addr(req1_addr),
    .req1_wdata(req1_wdata), .req1_ready(req1_ready),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_rdata(rsp_rdata), .busy(busy),
    .mem_en(mem_en), .mem_rw(mem_rw), .mem_ras(mem_ras), .mem_cas(mem_cas),
    .mem_address(mem_address), .mem_datain(mem_datain), .mem_dataout(mem_dataout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory model: ras/cas low latch row/column, en performs the access.
  logic [7:0] mem [32];
  logic [2:0] m_row = 3'd0;
  logic [1:0] m_col = 2'd0;
  initial for (int i = 0; i < 32; i++) mem[i] = 8'd0;
  always @(posedge clk) begin
    if (!mem_ras) m_row <= mem_address[4:2];
    if (!mem_cas) m_col <= mem_address[1:0];
    if (mem_en) begin
      if (mem_rw) mem[{m_row, m_col}] <= mem_datain;
      else        mem_dataout <= mem[{m_row, m_col}];
    end
  end

  task automatic step();
    @(negedge clk); #1;
  endtask

  // Present a request and hold it until accepted; returns in cycle T0+1.
  task automatic issue(input bit port, input bit we, input logic [4:0] addr,
                       input logic [7:0] wd, output int k, output bit ok);
    ok = 1'b0; k = 0;
    if (port) begin req1_valid = 1; req1_we = we; req1_addr = addr; req1_wdata = wd; end
    else      begin req0_valid = 1; req0_we = we; req0_addr = addr; req0_wdata = wd; end
    #1;
    for (int i = 0; i < 50 && !ok; i++) begin
      if (port ? req1_ready : req0_ready) begin ok = 1'b1; k = cyc; end
      else step();
    end
    step();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  task automatic watch(input int n, output int ras_cnt, output int rsp_at,
                       output logic [7:0] d, output logic id);
    ras_cnt = 0; rsp_at = -1; d = 8'd0; id = 1'b0;
    for (int j = 0; j < n; j++) begin
      if (j > 0) step();
      if (!mem_ras) ras_cnt++;
      if (rsp_valid && rsp_at < 0) begin rsp_at = cyc; d = rsp_rdata; id = rsp_id; end
    end
  endtask

  task automatic test_reset();
    int k, bad; bit ok;
    req0_valid = 1'b1; req1_valid = 1'b1; rst = 1'b1;
    step(); step();
    n_checks++;
    if ({req0_ready, req1_ready} !== 2'b00) begin
      n_fail++; $display("FAIL reset_ready: got %b required 00", {req0_ready, req1_ready});
    end
    n_checks++;
    if ({mem_ras, mem_cas, mem_en, mem_rw, mem_address, mem_datain, busy} !== {4'b1100, 5'd0, 8'd0, 1'b0}) begin
      n_fail++; $display("FAIL reset_strobes: ras%b cas%b en%b rw%b a%h d%h busy%b", mem_ras, mem_cas, mem_en, mem_rw, mem_address, mem_datain, busy);
    end
    n_checks++;
    if ({rsp_valid, rsp_id, rsp_rdata} !== 10'd0) begin
      n_fail++; $display("FAIL reset_rsp: valid%b id%b data%h required all zero", rsp_valid, rsp_id, rsp_rdata);
    end
    req0_valid = 1'b0; req1_valid = 1'b0; rst = 1'b0;
    step();
    issue(1'b0, 1'b0, 5'd3, 8'd0, k, ok);
    step();
    n_checks++;
    if (!ok || mem_cas !== 1'b0) begin
      n_fail++; $display("FAIL reset_reach_col: accepted %b cas %b required 1/0", ok, mem_cas);
    end
    rst = 1'b1;
    step();
    n_checks++;
    if ({mem_ras, mem_cas, mem_en, busy} !== 4'b1100) begin
      n_fail++; $display("FAIL reset_abort: ras%b cas%b en%b busy%b required 1 1 0 0", mem_ras, mem_cas, mem_en, busy);
    end
    step();
    rst = 1'b0;
    bad = 0;
    for (int j = 0; j < 8; j++) begin
      step();
      if (rsp_valid || mem_en) bad++;
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++; $display("FAIL reset_no_access: %0d cycles with en/rsp_valid, required 0", bad);
    end
  endtask

  task automatic test_round_trip();
    int k, rc, at; bit ok; logic [7:0] d; logic id;
    issue(1'b0, 1'b1, 5'd13, 8'hA5, k, ok);
    n_checks++;
    if (!ok || {mem_ras, mem_cas, mem_en, mem_address} !== {3'b010, 5'b01100}) begin
      n_fail++; $display("FAIL rt_row: ras%b cas%b en%b a%b required 0 1 0 01100", mem_ras, mem_cas, mem_en, mem_address);
    end
    step();
    n_checks++;
    if ({mem_ras, mem_cas, mem_en, mem_address} !== {3'b100, 5'b00001}) begin
      n_fail++; $display("FAIL rt_col: ras%b cas%b en%b a%b required 1 0 0 00001", mem_ras, mem_cas, mem_en, mem_address);
    end
    step();
    n_checks++;
    if ({mem_ras, mem_cas, mem_en, mem_rw, mem_datain} !== {4'b1111, 8'hA5}) begin
      n_fail++; $display("FAIL rt_acc: ras%b cas%b en%b rw%b d%h required 1 1 1 1 a5", mem_ras, mem_cas, mem_en, mem_rw, mem_datain);
    end
    step();
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL rt_write_done: busy %b at T0+4 required 0", busy);
    end
    issue(1'b0, 1'b0, 5'd13, 8'd0, k, ok);
    watch(6, rc, at, d, id);
    n_checks++;
    if (!ok || at - k != (HIT ? 4 : 5)) begin
      n_fail++; $display("FAIL rt_read_lat: got %0d required %0d", at - k, HIT ? 4 : 5);
    end
    n_checks++;
    if (d !== 8'hA5 || id !== 1'b0) begin
      n_fail++; $display("FAIL rt_read_data: got %h id %b required a5 id 0", d, id);
    end
  endtask

  task automatic test_arbitration();
    int order[4], gk[4], ng, k, rc, at; bit prev, ok; logic [7:0] d; logic id;
    rst = 1'b1;
    req0_valid = 1; req0_we = 1; req0_addr = 5'd0;  req0_wdata = 8'h11;
    req1_valid = 1; req1_we = 1; req1_addr = 5'd31; req1_wdata = 8'h22;
    step(); step();
    rst = 1'b0; #1;
    ng = 0; prev = 1'b0;
    for (int s = 0; s < 60 && ng < 4; s++) begin
      if (s > 0) step();
      if (prev) begin
        n_checks++;
        if (req0_ready || req1_ready) begin
          n_fail++; $display("FAIL arb_ready_pulse: ready held past handshake (%b%b)", req0_ready, req1_ready);
        end
        prev = 1'b0;
      end
      if (req0_ready || req1_ready) begin
        order[ng] = int'(req1_ready); gk[ng] = cyc; ng++; prev = 1'b1;
      end
    end
    step();
    req0_valid = 1'b0; req1_valid = 1'b0;
    n_checks++;
    if (ng != 4) begin
      n_fail++; $display("FAIL arb_grants: got %0d grants required 4", ng);
    end
    for (int i = 0; i < ng; i++) begin
      n_checks++;
      if (order[i] != (i % 2)) begin
        n_fail++; $display("FAIL arb_order: grant %0d to port %0d required %0d", i, order[i], i % 2);
      end
    end
    for (int i = 1; i < ng; i++) begin
      n_checks++;
      if (gk[i] - gk[i-1] != 4) begin
        n_fail++; $display("FAIL arb_interval: got %0d required 4", gk[i] - gk[i-1]);
      end
    end
    for (int i = 0; i < 10 && busy; i++) step();
    issue(1'b0, 1'b0, 5'd31, 8'd0, k, ok);
    watch(6, rc, at, d, id);
    n_checks++;
    if (!ok || d !== 8'h22 || id !== 1'b0) begin
      n_fail++; $display("FAIL arb_read31: got %h id %b required 22 id 0", d, id);
    end
    issue(1'b1, 1'b0, 5'd0, 8'd0, k, ok);
    watch(6, rc, at, d, id);
    n_checks++;
    if (!ok || d !== 8'h11 || id !== 1'b1) begin
      n_fail++; $display("FAIL arb_read0: got %h id %b required 11 id 1", d, id);
    end
  endtask

  task automatic test_single_requester();
    int k0, k1, k2; bit ok0, ok1, ok2;
    issue(1'b1, 1'b1, 5'd16, 8'h5A, k0, ok0);
    issue(1'b1, 1'b1, 5'd20, 8'h6B, k1, ok1);
    issue(1'b1, 1'b1, 5'd24, 8'h7C, k2, ok2);
    n_checks++;
    if (!(ok0 && ok1 && ok2)) begin
      n_fail++; $display("FAIL single_grant: accepted %b%b%b required 111", ok0, ok1, ok2);
    end
    n_checks++;
    if (k1 - k0 != 4 || k2 - k1 != 4) begin
      n_fail++; $display("FAIL single_interval: got %0d,%0d required 4,4", k1 - k0, k2 - k1);
    end
    for (int i = 0; i < 10 && busy; i++) step();
  endtask

  task automatic test_back_to_back();
    int k, nok, idx, got; bit ok, hs; logic [7:0] exp;
    nok = 0;
    for (int i = 0; i < 32; i++) begin
      issue(1'b0, 1'b1, 5'(i), 8'hF0 ^ 8'(i), k, ok);
      if (ok) nok++;
    end
    n_checks++;
    if (nok != 32) begin
      n_fail++; $display("FAIL sweep_writes: accepted %0d required 32", nok);
    end
    for (int i = 0; i < 10 && busy; i++) step();
    req0_we = 1'b0; req0_addr = 5'd0; req0_valid = 1'b1; #1;
    idx = 0; got = 0; hs = 1'b0;
    for (int s = 0; s < 400 && got < 32; s++) begin
      if (s > 0) step();
      if (hs) begin
        hs = 1'b0; idx++;
        if (idx < 32) req0_addr = 5'(idx);
        else          req0_valid = 1'b0;
      end
      if (rsp_valid) begin
        exp = 8'hF0 ^ 8'(got);
        n_checks++;
        if (rsp_rdata !== exp) begin
          n_fail++; $display("FAIL sweep_data[%0d]: got %h required %h", got, rsp_rdata, exp);
        end
        if (got < 31) begin
          n_checks++;
          if (req0_ready !== 1'b1) begin
            n_fail++; $display("FAIL sweep_overlap[%0d]: ready %b with rsp_valid, required 1", got, req0_ready);
          end
        end
        got++;
      end
      if (req0_valid && req0_ready) hs = 1'b1;
    end
    req0_valid = 1'b0;
    n_checks++;
    if (got != 32) begin
      n_fail++; $display("FAIL sweep_count: got %0d responses required 32", got);
    end
    for (int i = 0; i < 10 && busy; i++) step();
  endtask

  task automatic test_row_hit();
    int k, rc, at; bit ok; logic [7:0] d; logic id;
    rst = 1'b1; step(); step(); rst = 1'b0; step();
    issue(1'b0, 1'b0, 5'd8, 8'd0, k, ok);
    watch(6, rc, at, d, id);
    n_checks++;
    if (!ok || rc != 1 || at - k != 5) begin
      n_fail++; $display("FAIL hit_first: ras_low %0d lat %0d required 1 and 5", rc, at - k);
    end
    n_checks++;
    if (d !== 8'hF8) begin
      n_fail++; $display("FAIL hit_first_data: got %h required f8", d);
    end
    issue(1'b0, 1'b0, 5'd10, 8'd0, k, ok);
    watch(6, rc, at, d, id);
    n_checks++;
    if (!ok || rc != (HIT ? 0 : 1) || at - k != (HIT ? 4 : 5)) begin
      n_fail++; $display("FAIL hit_second: ras_low %0d lat %0d required %0d and %0d", rc, at - k, HIT ? 0 : 1, HIT ? 4 : 5);
    end
    n_checks++;
    if (d !== 8'hFA) begin
      n_fail++; $display("FAIL hit_second_data: got %h required fa", d);
    end
  endtask

  initial begin
    test_reset();
    test_round_trip();
    test_arbitration();
    test_single_requester();
    test_back_to_back();
    test_row_hit();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/sdram32_ctrl.md
# sdram32_ctrl

Two-port request controller for the 32×8 RAS/CAS-strobed SDRAM-style memory (8 rows × 4 columns). It arbitrates round-robin between two requesters and sequences the memory's multiplexed 5-bit address through row-latch, column-latch and access cycles. For reads, it captures the memory's registered read data and returns it to the requester that issued the read. It sits between the client logic and the memory macro, and it is the only driver of the memory's strobes.

## Interface
- No parameters (geometry fixed: row = addr[4:2], column = addr[1:0], data 8 bits).
- clk  in  1  rising-edge clock, shared with memory.
- rst  in  1  synchronous reset, active-high.
- req0_valid / req1_valid  in  1  request present.
- req0_we / req1_we  in  1  1 = write, 0 = read.
- req0_addr / req1_addr  in  5  word address.
- req0_wdata / req1_wdata  in  8  write data.
- req0_ready / req1_ready  out  1  request accepted this cycle.
- rsp_valid  out  1  one-cycle read-data strobe.
- rsp_id  out  1  requester index of rsp_rdata.
- rsp_rdata  out  8  read data.
- busy  out  1  FSM not in IDLE.
- mem_en  out  1  to memory en.
- mem_rw  out  1  to memory rw (1 = write, 0 = read).
- mem_ras  out  1  to memory ras (active-low latch).
- mem_cas  out  1  to memory cas (active-low latch).
- mem_address  out  5  to memory address.
- mem_datain  out  8  to memory datain.
- mem_dataout  in  8  from memory dataout.

## Operation
- **States:** IDLE, ROW, COL, ACC, CAP.
- **IDLE:**
  - Grant = the only valid requester. If both are valid, grant the requester named by the priority pointer `prio`.
  - reqN_ready = (state==IDLE) && grant==N. This is the only combinational input→output path.
  - On handshake: latch we/addr/wdata/id into internal regs, set `prio` = other requester, go to ROW.
- **ROW:** mem_ras=0, mem_cas=1, mem_en=0, mem_address={row,2'b00}. Go to COL.
- **COL:** mem_ras=1, mem_cas=0, mem_en=0, mem_address={3'b000,col}. Go to ACC.
- **ACC:** mem_ras=1, mem_cas=1, mem_en=1, mem_rw=we, mem_datain=wdata.
  - Write: go to IDLE.
  - Read: go to CAP.
- **CAP:** all strobes idle.
  - At the end of this cycle, rsp_rdata ← mem_dataout and rsp_id ← latched id.
  - rsp_valid=1 for the following single cycle. Go to IDLE.
- **Idle strobes** (IDLE, CAP): mem_ras=1, mem_cas=1, mem_en=0, mem_rw=0, mem_address=0, mem_datain=0.
- All mem_* outputs are registered, or decoded solely from the state and latched-request registers; they never depend on req inputs.
- **Reset values:** state IDLE, prio=0, mem_ras=1, mem_cas=1, mem_en=0, mem_rw=0, mem_address=0, mem_datain=0, reqN_ready=0 (held during rst), rsp_valid=0, rsp_id=0, rsp_rdata=0, busy=0.
- **Reset mid-operation:** abort immediately, with no memory access issued afterwards and no rsp_valid. The open-row tracker is cleared.
- **No queueing:** a request not accepted must be held by the requester.

## Timing
- Handshake edge = T0.
- Write: ROW at T0+1, COL at T0+2, ACC at T0+3; back in IDLE at T0+4, where it can accept the next request.
- Read: ROW through ACC as above, CAP at T0+4; rsp_valid high during T0+5 (IDLE), and the next request may also be accepted in that cycle.
- Throughput, back-to-back: write = one every 4 cycles; read = one every 5 cycles.
- rsp_valid and a new handshake may coincide. A response is never back-pressured.

## Configuration
- **Macro:** `SDRAM32_CTRL_ROW_HIT_EN`.
- **Defined:**
  - The controller tracks `open_row` plus `open_valid`. `open_valid` is set when ROW executes and cleared on rst.
  - If the accepted request's row equals `open_row` and `open_valid`=1, ROW is skipped: IDLE→COL directly.
  - With a skip, write latency is 3 cycles and a read's rsp_valid comes at T0+4.
- **Undefined:** ROW is always executed; timing is exactly as above.

## Test plan
- **Reset:** rst high 2 cycles during a read at state COL → next cycle mem_ras=1, mem_cas=1, mem_en=0; rsp_valid never asserts; busy=0.
- **Write/read round trip:** req0 write addr 5'd13, data 8'hA5, then req0 read addr 13.
  - Observe ras low with mem_address=5'b01100, then cas low with 5'b00001, then en=1 with rw=1.
  - Read returns rsp_valid at T0+5 with rsp_rdata=8'hA5 and rsp_id=0.
- **Arbitration:** both requesters valid continuously from reset.
  - Grants go 0,1,0,1 (each accepted request's ready pulses one cycle).
  - Writes to addrs 0 and 31 with data 8'h11 and 8'h22 read back correctly by the opposite port.
- **Single requester:** only req1 valid repeatedly → granted every time regardless of `prio`; the write-only acceptance interval is exactly 4 cycles.
- **Full sweep:** write addr i with data 8'hF0^i for i=0..31, then read all 32 → every rsp_rdata matches, no rsp_valid lost; rsp_valid coincides with the next read's acceptance.
- **ROW_HIT_EN** (compiled both ways): read addr 8 then addr 10 (same row 2).
  - With macro: the second read has no ras-low cycle and rsp_valid at T0+4.
  - Without macro: ras low on both reads and rsp_valid at T0+5.
  - After rst, the first access always executes ROW.
